// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM round-robin read arbiter.
// ROM geometry defaults plus the transaction FSM state encoding.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // Increment a requester index, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Upper half of the double-width vector is the unmasked request set, so it only wins when the masked half is empty.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0]   low_mask;
  logic [2*NUM_REQ-1:0] req_dbl;
  int                   pos;

  always_comb begin
    low_mask = (NUM_REQ'(1) << ptr_i) - NUM_REQ'(1);
    req_dbl  = {req_i, req_i & ~low_mask};
    pos      = 0;
    // Scanning downward leaves pos at the lowest set bit.
    for (int p = 2*NUM_REQ-1; p >= 0; p--) begin
      if (req_dbl[p]) begin
        pos = p;
      end
    end
    gnt_idx_o = (pos >= NUM_REQ) ? ID_W'(pos - NUM_REQ) : ID_W'(pos);
    any_o     = |req_i;
    gnt_o     = any_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Shares one single-port registered-output ROM among NUM_REQ requesters, one read in flight.
// Accept at edge N, rsp_valid from cycle N+2; response holds until rsp_ready, no accepts meanwhile.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       rsp_ready,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [ID_W-1:0]    grant_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic               rom_en_q;
  logic               rsp_valid_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        addr_d = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    rr_ptr_d = ID_W'(wrap_inc(int'(arb_idx), NUM_REQ));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      rom_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_idx;
            addr_q   <= addr_d;
            rr_ptr_q <= rr_ptr_d;
            rom_en_q <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          rom_en_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rom_en_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // ROM output only changes after an en cycle, so rom_data stays valid for the whole RESP.
  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
  assign rom_en    = rom_en_q;
  assign rom_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_valid_q ? grant_q : '0;
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Scoreboard bench for rom_rr_arbiter with a ROM model returning addr+1.
module tb_rom_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        rom_en;
  logic [2:0]  rom_addr;
  logic [7:0]  rom_q = 8'h00;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t sb[$];
  int   tb_addr[4];
  int   checks = 0;
  int   errors = 0;
  int   nrsp   = 0;
  int   cnt;

  rom_rr_arbiter #(.NUM_REQ(4), .ADDR_W(3), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_q <= {5'b0, rom_addr} + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input int a);
    tb_addr[i] = a;
    req_addr[i*3 +: 3] = 3'(a);
  endtask

  // Called just after a rising edge; returns at the falling edge of the accept cycle.
  task automatic wait_grant(input int exp_w, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("grant", {28'b0, req_ready}, 32'(1 << exp_w));
    e.id   = exp_w;
    e.data = (tb_addr[exp_w] + 1) & 8'hff;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", {30'b0, rsp_id}, 32'(e.id));
        chk("rsp_data", {24'b0, rsp_data}, 32'(e.data));
        nrsp++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wrap_seq[3];
    wrap_seq[0] = 0; wrap_seq[1] = 1; wrap_seq[2] = 0;
    rst = 1'b1; req_valid = 4'b0; req_addr = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, i);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
    chk("rst_rom_en", {31'b0, rom_en}, 32'd0);
    chk("rst_rom_addr", {29'b0, rom_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Round-robin with everyone requesting
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % 4, cnt);
      if (k > 0) chk("rr_gap", 32'(cnt + 1), 32'd3);
      @(posedge clk); #1;
    end
    req_valid = 4'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single read from requester 2
    set_addr(2, 5);
    req_valid = 4'b0100;
    wait_grant(2, cnt);
    chk("single_lat", 32'(cnt), 32'd0);
    @(posedge clk); #1 req_valid = 4'b0;
    @(negedge clk);
    chk("single_rom_en", {31'b0, rom_en}, 32'd1);
    chk("single_rom_addr", {29'b0, rom_addr}, 32'd5);
    chk("single_rdy_read", {28'b0, req_ready}, 32'd0);
    chk("single_vld_read", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("single_rsp_id", {30'b0, rsp_id}, 32'd2);
    chk("single_rsp_data", {24'b0, rsp_data}, 32'h06);
    chk("single_rom_en_resp", {31'b0, rom_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_idle", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // Wrap and skip: pointer sits at 3, only 0 and 1 request
    set_addr(0, 3);
    set_addr(1, 7);
    req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_grant(wrap_seq[k], cnt);
      @(posedge clk); #1;
    end
    req_valid = 4'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure, with a request from 1 that is withdrawn before IDLE
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    wait_grant(3, cnt);
    @(posedge clk); #1 req_valid = 4'b0;
    @(posedge clk); #1 req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_id", {30'b0, rsp_id}, 32'd3);
      chk("bp_rsp_data", {24'b0, rsp_data}, 32'h04);
      chk("bp_rom_en", {31'b0, rom_en}, 32'd0);
      chk("bp_req_ready", {28'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("wd_req_ready", {28'b0, req_ready}, 32'd0);
    chk("wd_rom_en", {31'b0, rom_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_rom_en2", {31'b0, rom_en}, 32'd0);
    chk("wd_req_ready2", {28'b0, req_ready}, 32'd0);
    @(posedge clk); #1;

    // Reset while a response is pending
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grant(2, cnt);
    @(posedge clk); #1 req_valid = 4'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("mid_rst_rom_en", {31'b0, rom_en}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    wait_grant(0, cnt);
    @(posedge clk); #1 req_valid = 4'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("rsp_count", 32'(nrsp), 32'd11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
